elevator_scheduler: RTL and testbench

Sequencing controller for a single 5-floor elevator car. Latches car calls and up/down hall calls, chooses the next stop with a SCAN (directional collector) policy, and steps the car one floor at a time through a request/acknowledge handshake with the motion datapath. Drives the door timer and reports current floor, travel direction and the pending-call vector to the rest of the design.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_door_timer.sv | 37 +++
 rtl/elevator_scheduler.sv | 137 +++++++++++++
 tb/tb_elevator_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the single-car elevator scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDecide,
    StMove,
    StDoor
  } state_e;

  typedef enum logic [1:0] {
    DirIdle = 2'b00,
    DirUp   = 2'b01,
    DirDown = 2'b10
  } dir_e;

  localparam int unsigned FloorsDefault     = 5;
  localparam int unsigned DoorCyclesDefault = 8;

endpackage

// File: rtl/elevator_door_timer.sv
// Door-open countdown: load on stop entry, count while enabled, done on the last open cycle.
module elevator_door_timer #(
  parameter int unsigned Cycles = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  input  logic hold_i,
  output logic done_o
);

  localparam int unsigned CntW = (Cycles > 2) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Loading Cycles-1 and finishing at zero gives exactly Cycles open cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || (en_i && hold_i)) begin
      cnt_d = CntW'(Cycles - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && !hold_i && (cnt_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN scheduler for one elevator car: call latching, stop selection, step handshake, door.
// Define ELEVATOR_DOOR_HOLD_EN to add the door_hold_i port that extends the door-open time.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned Floors     = FloorsDefault,
  parameter int unsigned DoorCycles = DoorCyclesDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [Floors-1:0] floor_i,
  input  logic [Floors-1:0] up_i,
  input  logic [Floors-1:0] down_i,
  input  logic              step_ack_i,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic              door_hold_i,
`endif
  output logic              step_req_o,
  output logic [2:0]        floor_number_o,
  output logic [1:0]        dir_o,
  output logic [Floors-1:0] to_go_o,
  output logic              door_open_o
);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [2:0]        floor_q, floor_d;
  logic [Floors-1:0] car_q, car_d, up_q, up_d, down_q, down_d;

  logic [Floors-1:0] to_go, here_mask, absorb;
  logic              above, below, here;
  logic              door_load, door_done, door_hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign door_hold = door_hold_i;
`else
  assign door_hold = 1'b0;
`endif

  assign to_go     = car_q | up_q | down_q;
  assign here_mask = {{(Floors-1){1'b0}}, 1'b1} << floor_q;
  // A call arriving at the current floor is served directly rather than latched.
  assign here      = |(here_mask & (to_go | floor_i | up_i | down_i));

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < int'(Floors); i++) begin
      if (to_go[i] && (i > int'(floor_q))) above = 1'b1;
      if (to_go[i] && (i < int'(floor_q))) below = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    door_load = 1'b0;
    case (state_q)
      StIdle, StDecide: begin
        if (here) begin
          state_d   = StDoor;
          door_load = 1'b1;
        end else if ((dir_q == DirUp) && above) begin
          state_d = StMove;
        end else if ((dir_q == DirDown) && below) begin
          state_d = StMove;
        end else if (above) begin
          state_d = StMove;
          dir_d   = DirUp;
        end else if (below) begin
          state_d = StMove;
          dir_d   = DirDown;
        end else begin
          state_d = StIdle;
          dir_d   = DirIdle;
        end
      end
      StMove: begin
        if (step_ack_i) begin
          state_d = StDecide;
          if (dir_q == DirUp) begin
            if (floor_q < 3'(Floors - 1)) floor_d = floor_q + 3'd1;
          end else if (dir_q == DirDown) begin
            if (floor_q != 3'd0) floor_d = floor_q - 3'd1;
          end
        end
      end
      StDoor: begin
        if (door_done) state_d = StDecide;
      end
      default: state_d = StIdle;
    endcase
  end

  // Entering or sitting in DOOR clears and blocks the current floor's calls.
  assign absorb = ((state_q == StDoor) || door_load) ? here_mask : '0;
  assign car_d  = (car_q | floor_i) & ~absorb;
  assign up_d   = (up_q | up_i) & ~absorb;
  assign down_d = (down_q | down_i) & ~absorb;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dir_q   <= DirIdle;
      floor_q <= 3'd0;
      car_q   <= '0;
      up_q    <= '0;
      down_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      car_q   <= car_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  elevator_door_timer #(
    .Cycles(DoorCycles)
  ) u_door_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i(door_load),
    .en_i  (state_q == StDoor),
    .hold_i(door_hold),
    .done_o(door_done)
  );

  assign step_req_o     = (state_q == StMove);
  assign door_open_o    = (state_q == StDoor);
  assign floor_number_o = floor_q;
  assign dir_o          = dir_q;
  assign to_go_o        = to_go;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench: directed scenarios plus random calls against a pending-set model.
module tb_elevator_scheduler;

  localparam int F  = 5;
  localparam int DC = 8;

  logic         clk, rst_n;
  logic [F-1:0] floor_in, up_in, dn_in;
  logic         step_ack;
  logic         step_req, door_open;
  logic [2:0]   floor_number;
  logic [1:0]   dir;
  logic [F-1:0] to_go;

  int n_checks = 0;
  int n_pass   = 0;

  elevator_scheduler #(
    .Floors    (F),
    .DoorCycles(DC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .floor_i       (floor_in),
    .up_i          (up_in),
    .down_i        (dn_in),
    .step_ack_i    (step_ack),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold_i   (1'b0),
`endif
    .step_req_o    (step_req),
    .floor_number_o(floor_number),
    .dir_o         (dir),
    .to_go_o       (to_go),
    .door_open_o   (door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a set of pending floors, a mode, a floor, a direction and a door countdown.
  localparam int MIdle = 0, MDecide = 1, MMove = 2, MDoor = 3;
  int m_mode, m_floor, m_dir, m_left;
  bit m_pend[F];

  task automatic model_step();
    bit called[F];
    bit above, below, here, absorb;
    int f;
    f = m_floor;
    above = 0;
    below = 0;
    for (int i = 0; i < F; i++) begin
      called[i] = floor_in[i] | up_in[i] | dn_in[i];
      if (m_pend[i] && i > f) above = 1;
      if (m_pend[i] && i < f) below = 1;
    end
    here   = m_pend[f] || called[f];
    absorb = (m_mode == MDoor);
    if (m_mode == MIdle || m_mode == MDecide) begin
      if (here) begin
        m_mode = MDoor;
        m_left = DC;
        absorb = 1;
      end else if ((m_dir == 1 && above) || (m_dir == 2 && below)) begin
        m_mode = MMove;
      end else if (above) begin
        m_mode = MMove;
        m_dir  = 1;
      end else if (below) begin
        m_mode = MMove;
        m_dir  = 2;
      end else begin
        m_mode = MIdle;
        m_dir  = 0;
      end
    end else if (m_mode == MMove) begin
      if (step_ack) begin
        if (m_dir == 1) m_floor = (f + 1 > F - 1) ? F - 1 : f + 1;
        else            m_floor = (f - 1 < 0) ? 0 : f - 1;
        m_mode = MDecide;
      end
    end else begin
      if (m_left == 1) m_mode = MDecide;
      else m_left--;
    end
    for (int i = 0; i < F; i++) begin
      if (absorb && i == f) m_pend[i] = 0;
      else m_pend[i] = m_pend[i] | called[i];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = MIdle;
      m_floor = 0;
      m_dir   = 0;
      m_left  = 0;
      for (int i = 0; i < F; i++) m_pend[i] = 0;
    end else begin
      model_step();
    end
  end

  function automatic logic [11:0] model_out();
    logic [F-1:0] pend;
    for (int i = 0; i < F; i++) pend[i] = m_pend[i];
    return {m_mode == MMove, 3'(m_floor), 2'(m_dir), pend, m_mode == MDoor};
  endfunction

  always @(negedge clk) begin
    if (rst_n) check("model", {step_req, floor_number, dir, to_go, door_open}, model_out());
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    floor_in = '0; up_in = '0; dn_in = '0; step_ack = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic handshake();
    int w = 0;
    while (!step_req && w < 20) begin tick(); w++; end
    check("step_req_wait", step_req, 1);
    step_ack = 1;
    tick();
    step_ack = 0;
  endtask

  task automatic count_door(output int n);
    int w = 0;
    n = 0;
    while (!door_open && w < 40) begin tick(); w++; end
    while (door_open && n < 40) begin n++; tick(); end
  endtask

  task automatic pulse_car(input logic [F-1:0] v);
    floor_in = v;
    tick();
    floor_in = '0;
  endtask

  int n;

  initial begin
    rst_n = 0; floor_in = '0; up_in = '0; dn_in = '0; step_ack = 0;

    // Reset held with a call present: nothing latches.
    floor_in = 5'b10000;
    repeat (3) tick();
    check("rst_outputs", {step_req, floor_number, dir, to_go, door_open}, 12'h000);
    rst_n = 1;
    tick();
    check("to_go_after_release", to_go, 5'b10000);
    floor_in = '0;

    // Car call to the top floor.
    handshake();
    check("b_dir_up", dir, 2'b01);
    repeat (3) handshake();
    check("b_floor4", floor_number, 3'd4);
    count_door(n);
    check("b_door_len", n, DC);
    tick();
    check("b_to_go_clear", to_go, 5'b00000);
    check("b_dir_idle", dir, 2'b00);

    // Two stops on the way up.
    do_reset();
    pulse_car(5'b01010);
    handshake();
    check("c_floor1", floor_number, 3'd1);
    count_door(n);
    check("c_door1_len", n, DC);
    handshake();
    handshake();
    check("c_floor3", floor_number, 3'd3);
    check("c_dir_up", dir, 2'b01);
    count_door(n);
    check("c_door3_len", n, DC);

    // At floor 2 heading up with calls above and below: up first, then down.
    do_reset();
    pulse_car(5'b00100);
    handshake();
    handshake();
    pulse_car(5'b10001);
    count_door(n);
    check("d_door2_len", n, DC);
    handshake();
    handshake();
    check("d_floor4", floor_number, 3'd4);
    count_door(n);
    handshake();
    check("d_dir_down", dir, 2'b10);
    repeat (3) handshake();
    check("d_floor0", floor_number, 3'd0);
    count_door(n);
    tick();
    check("d_idle", {dir, to_go}, 7'd0);

    // Hall call at the idle car's floor opens the door without latching.
    do_reset();
    pulse_car(5'b00100);
    handshake();
    handshake();
    count_door(n);
    repeat (2) tick();
    up_in = 5'b00100;
    tick();
    up_in = '0;
    check("e_door_now", {step_req, door_open}, 2'b01);
    check("e_to_go_zero", to_go, 5'b00000);
    count_door(n);
    check("e_door_len", n, DC);
    check("e_to_go_after", to_go, 5'b00000);

    // Asynchronous reset during a step request.
    do_reset();
    pulse_car(5'b10000);
    handshake();
    begin
      int w = 0;
      while (!step_req && w < 20) begin tick(); w++; end
    end
    #2 rst_n = 0;
    #1 check("f_async", {step_req, floor_number, dir, to_go, door_open}, 12'h000);
    tick();
    rst_n = 1;
    step_ack = 1;
    tick();
    step_ack = 0;
    tick();
    check("f_ack_ignored", {step_req, floor_number, to_go}, 9'd0);

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      floor_in = ($urandom_range(0, 9) == 0) ? F'(1 << $urandom_range(0, F - 1)) : '0;
      up_in    = ($urandom_range(0, 14) == 0) ? F'(1 << $urandom_range(0, F - 1)) : '0;
      dn_in    = ($urandom_range(0, 14) == 0) ? F'(1 << $urandom_range(0, F - 1)) : '0;
      step_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 0;
        #1 check("rand_async", {step_req, floor_number, dir, to_go, door_open}, 12'h000);
        tick();
        rst_n = 1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
